openhw_uncore_sched: RTL and testbench
======================================

// Module: openhw_uncore_sched
// PURPOSE
//  Schedules accesses from two requesters (instruction fetch I, data D) onto the single shared
//  AHB-Lite uncore bus that fronts the physical-memory region decoders. Round-robin arbitration.
//  Drives the address phase and registers the one-hot region select into the data phase.
//  Acts as the default slave for unmapped addresses (SelRegions[0]).
// PARAMETERS
//  PA_BITS        34   physical address width
//  NREG           11   region-select width; bit 0 = "no region hit"
//  TIMEOUT_CYC    256  data-phase wait limit (TIMEOUT_EN only); 2..65535
// PORTS
//  HCLK         in   1        clock
//  HRESETn      in   1        asynchronous active-low reset
//  IReq         in   1        I request; held until IGnt done
//  IAdr         in   PA_BITS  I physical address
//  DReq         in   1        D request; held until DDone
//  DAdr         in   PA_BITS  D physical address
//  DWrite       in   1        D write (I is always read)
//  SelRegions   in   NREG     one-hot decode of HADDR, combinational from region decoders
//  HREADY       in   1        selected slave ready (from slave mux)
//  HADDR        out  PA_BITS  bus address (address phase)
//  HWRITE       out  1        bus write
//  HTRANS       out  2        2'b10 NONSEQ in address phase, else 2'b00 IDLE
//  HSELData     out  NREG     region select registered for data phase
//  IDone        out  1        I transfer complete this cycle
//  DDone        out  1        D transfer complete this cycle
//  BusErr       out  1        completing transfer errored (with IDone/DDone)
// BEHAVIOUR
//  Reset: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSELData=0, IDone=DDone=BusErr=0, prio=D.
//  FSM IDLE->ADDR->DATA->IDLE; DATA->ERR1->ERR2->IDLE on unmapped.
//  IDLE: any req -> latch owner (prio on tie), ADDR next cycle. No req: stay.
//  ADDR (1 cyc): HTRANS=10, HADDR/HWRITE from owner; HSELData<=SelRegions at cycle end.
//   SelRegions[0]=1 -> ERR1 (no slave selected, HSELData[0]=1); else DATA.
//  DATA: wait HREADY=1 -> pulse owner Done for 1 cyc, BusErr=0, IDLE.
//  ERR1: default slave response, no wait; ERR2 next. ERR2: owner Done=1, BusErr=1, IDLE.
//  Min latency req->Done: 3 cycles mapped, 4 cycles unmapped.
//  Round robin: prio flips to non-owner on every Done; last owner loses ties.
//  Requests deasserted before grant are dropped silently. Owner must not drop req mid-transfer.
//  HSELData cleared to 0 on entering IDLE; exactly one bit set in DATA/ERR1/ERR2.
//  HRESETn low mid-transfer: immediate return to reset values; no Done issued.
// CONFIGURATION
//  OPENHW_UNCORE_SCHED_TIMEOUT_EN defined: 16-bit counter counts DATA cycles with HREADY=0.
//   Reaching TIMEOUT_CYC -> ERR2 path (owner Done + BusErr), counter cleared; slave abandoned.
//  Undefined: no counter, DATA waits on HREADY indefinitely.
// STRUCTURE
//  Shared package: sched_state_t enum {IDLE,ADDR,DATA,ERR1,ERR2}; HTRANS_IDLE/HTRANS_NONSEQ
//   localparams; owner_t enum {OWN_I,OWN_D}.
//  Sub-module openhw_rr_arb2: 2-way round-robin arbiter (req[1:0], done, grant[1:0], prio flop).
// TESTING
//  IReq=1 alone, IAdr=0x8000_0000 mapped, HREADY=1 -> HTRANS=10 cyc1, IDone cyc3, BusErr=0.
//  IReq=DReq=1 after reset -> D granted first, I next; 4 alternating pairs alternate D,I,D,I.
//  DReq, DAdr=0x0 unmapped (SelRegions=1) -> HSELData=0x001, DDone+BusErr at cycle 4.
//  Mapped D write, HREADY low 5 cycles -> DDone exactly 1 cycle after HREADY rises, HWRITE=1.
//  HRESETn asserted in DATA -> next edge all outputs reset values, no Done; fresh req works.
//  TIMEOUT_EN, TIMEOUT_CYC=8, HREADY stuck 0 -> Done+BusErr after 8 waits; disabled: never.

Source files
------------

// File: rtl/openhw_uncore_sched_pkg.sv
// Shared types for the uncore bus scheduler: FSM states, bus owner, AHB transfer codes.
package openhw_uncore_sched_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR1, ERR2} sched_state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/openhw_rr_arb2.sv
// Two-way round-robin arbiter, combinational grant; the priority flop moves to the
// non-owner whenever a transfer completes, so the last owner loses the next tie.
module openhw_rr_arb2
  import openhw_uncore_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  owner_t     done_owner,
  output logic [1:0] grant
);

  owner_t prio_q, prio_d;

  // req/grant bit 0 is the I side, bit 1 the D side
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (prio_q == OWN_D) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (done) begin
      prio_d = other_owner(done_owner);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= OWN_D;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/openhw_uncore_sched.sv
// Schedules I/D requests onto the AHB-Lite uncore bus; Done arrives 3 cycles after request (4 unmapped).
// Waits on HREADY in the data phase; OPENHW_UNCORE_SCHED_TIMEOUT_EN adds a data-phase wait timeout.
module openhw_uncore_sched
  import openhw_uncore_sched_pkg::*;
#(
  parameter int PA_BITS     = 34,
  parameter int NREG        = 11,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               IReq,
  input  logic [PA_BITS-1:0] IAdr,
  input  logic               DReq,
  input  logic [PA_BITS-1:0] DAdr,
  input  logic               DWrite,
  input  logic [NREG-1:0]    SelRegions,
  input  logic               HREADY,
  output logic [PA_BITS-1:0] HADDR,
  output logic               HWRITE,
  output logic [1:0]         HTRANS,
  output logic [NREG-1:0]    HSELData,
  output logic               IDone,
  output logic               DDone,
  output logic               BusErr
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..65535");
  end

  sched_state_t    state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [NREG-1:0] hsel_q, hsel_d;
  logic            idone_q, idone_d;
  logic            ddone_q, ddone_d;
  logic            berr_q, berr_d;
  logic            xfer_done;
  logic            timeout;
  logic [1:0]      arb_req;
  logic [1:0]      grant;

  // A requester keeps its line high through its own Done cycle; hide it so it is not re-granted.
  assign arb_req = {DReq & ~ddone_q, IReq & ~idone_q};

  openhw_rr_arb2 u_arb (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .req       (arb_req),
    .done      (xfer_done),
    .done_owner(owner_q),
    .grant     (grant)
  );

`ifdef OPENHW_UNCORE_SCHED_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    timeout    = 1'b0;
    if (state_q == DATA && !HREADY) begin
      if (wait_cnt_q == WAIT_LAST) begin
        timeout = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hsel_d    = hsel_q;
    xfer_done = 1'b0;
    berr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        hsel_d = '0;
        if (grant != 2'b00) begin
          owner_d = grant[1] ? OWN_D : OWN_I;
          state_d = ADDR;
        end
      end
      ADDR: begin
        hsel_d  = SelRegions;
        state_d = SelRegions[0] ? ERR1 : DATA;
      end
      DATA: begin
        if (HREADY) begin
          xfer_done = 1'b1;
          hsel_d    = '0;
          state_d   = IDLE;
        end else if (timeout) begin
          // Slave is abandoned; finish through the error response path.
          state_d = ERR2;
        end
      end
      ERR1: begin
        state_d = ERR2;
      end
      ERR2: begin
        xfer_done = 1'b1;
        berr_d    = 1'b1;
        hsel_d    = '0;
        state_d   = IDLE;
      end
      default: begin
        hsel_d  = '0;
        state_d = IDLE;
      end
    endcase
    idone_d = xfer_done && (owner_q == OWN_I);
    ddone_d = xfer_done && (owner_q == OWN_D);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      hsel_q  <= '0;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hsel_q  <= hsel_d;
      idone_q <= idone_d;
      ddone_q <= ddone_d;
      berr_q  <= berr_d;
    end
  end

  assign HTRANS   = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR    = (state_q == ADDR) ? ((owner_q == OWN_D) ? DAdr : IAdr) : '0;
  assign HWRITE   = (state_q == ADDR) && (owner_q == OWN_D) && DWrite;
  assign HSELData = hsel_q;
  assign IDone    = idone_q;
  assign DDone    = ddone_q;
  assign BusErr   = berr_q;

endmodule

// File: tb/tb_openhw_uncore_sched.sv
// Bench for openhw_uncore_sched: directed vector table, hand-written corner sequences,
// then random I/D traffic checked cycle by cycle against a transaction-level model.
module tb_openhw_uncore_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IReq, DReq, DWrite, HREADY;
  logic [33:0] IAdr, DAdr, HADDR;
  logic [10:0] SelRegions, HSELData;
  logic [1:0]  HTRANS;
  logic        HWRITE, IDone, DDone, BusErr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Region decoder stand-in: bit 31 clear is unmapped, otherwise bits 30:28 pick region 1..8.
  function automatic logic [10:0] sel_of(input logic [33:0] a);
    if (!a[31]) return 11'h001;
    return 11'h002 << a[30:28];
  endfunction

  assign SelRegions = sel_of(HADDR);

  openhw_uncore_sched #(.PA_BITS(34), .NREG(11), .TIMEOUT_CYC(8)) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .IReq      (IReq),
    .IAdr      (IAdr),
    .DReq      (DReq),
    .DAdr      (DAdr),
    .DWrite    (DWrite),
    .SelRegions(SelRegions),
    .HREADY    (HREADY),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSELData  (HSELData),
    .IDone     (IDone),
    .DDone     (DDone),
    .BusErr    (BusErr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          ireq;
    bit          dreq;
    logic [33:0] adr;
    bit          wr;
    int          wait_cyc;
    int          exp_done;
    bit          exp_berr;
    logic [10:0] exp_hsel;
  } vec_t;

  task automatic do_reset();
    rst_n  = 1'b0;
    IReq   = 1'b0;
    DReq   = 1'b0;
    DWrite = 1'b0;
    HREADY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {HTRANS, HADDR, HWRITE, HSELData, IDone, DDone, BusErr}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single-requester transfer; cycle 0 is the cycle the request is first driven.
  task automatic apply_vec(input vec_t v);
    int got;
    bit berr_s;
    bit [1:0] who;
    got = -1;
    berr_s = 1'b0;
    who = 2'b00;
    @(posedge clk);
    #1;
    IReq = v.ireq; DReq = v.dreq;
    IAdr = v.adr;  DAdr = v.adr;
    DWrite = v.wr;
    HREADY = 1'b0;
    for (int c = 0; c < 40 && got < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1 HREADY = (c >= 2 + v.wait_cyc);
      end
      @(negedge clk);
      if (c == 0) chk("vec_htrans_c0", HTRANS, 2'b00);
      if (c == 1) begin
        chk("vec_htrans_addr", HTRANS, 2'b10);
        chk("vec_haddr", HADDR, v.adr);
        chk("vec_hwrite", HWRITE, v.dreq & v.wr);
      end
      if (c == 2) chk("vec_hsel", HSELData, v.exp_hsel);
      if (IDone || DDone) begin
        got = c;
        berr_s = BusErr;
        who = {DDone, IDone};
        chk("vec_hsel_at_done", HSELData, 11'h000);
      end
    end
    chk("vec_latency", got, v.exp_done);
    chk("vec_owner", who, {v.dreq, v.ireq});
    chk("vec_berr", berr_s, v.exp_berr);
    @(posedge clk);
    #1;
    IReq = 1'b0; DReq = 1'b0; HREADY = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [33:0] rand_adr();
    logic [33:0] a;
    a = {2'($urandom_range(3)), 32'($urandom)};
    a[31] = ($urandom_range(3) != 0);
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   cnt, first;
    bit   drop_i, drop_d;

    vt[0] = '{ireq:1'b1, dreq:1'b0, adr:34'h0_8000_0000, wr:1'b0, wait_cyc:0, exp_done:3, exp_berr:1'b0, exp_hsel:11'h002};
    vt[1] = '{ireq:1'b0, dreq:1'b1, adr:34'h0_0000_0000, wr:1'b0, wait_cyc:0, exp_done:4, exp_berr:1'b1, exp_hsel:11'h001};
    vt[2] = '{ireq:1'b0, dreq:1'b1, adr:34'h0_9000_0000, wr:1'b1, wait_cyc:5, exp_done:8, exp_berr:1'b0, exp_hsel:11'h004};
    vt[3] = '{ireq:1'b0, dreq:1'b1, adr:34'h3_F000_0000, wr:1'b0, wait_cyc:2, exp_done:5, exp_berr:1'b0, exp_hsel:11'h100};
    vt[4] = '{ireq:1'b1, dreq:1'b0, adr:34'h0_7FFF_FFFC, wr:1'b0, wait_cyc:0, exp_done:4, exp_berr:1'b1, exp_hsel:11'h001};
    vt[5] = '{ireq:1'b1, dreq:1'b0, adr:34'h2_C000_1234, wr:1'b0, wait_cyc:1, exp_done:4, exp_berr:1'b0, exp_hsel:11'h020};

    rst_n = 1'b0;
    IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0; HREADY = 1'b1;
    IAdr = '0; DAdr = '0;
    repeat (2) @(negedge clk);
    chk("init_htrans", HTRANS, 2'b00);
    chk("init_haddr", HADDR, 34'd0);
    chk("init_hwrite", HWRITE, 1'b0);
    chk("init_hsel", HSELData, 11'd0);
    chk("init_idone", IDone, 1'b0);
    chk("init_ddone", DDone, 1'b0);
    chk("init_buserr", BusErr, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 6; v++) apply_vec(vt[v]);

    // Both requesting from reset: D first, then strict alternation.
    do_reset();
    @(posedge clk);
    #1;
    IReq = 1'b1; DReq = 1'b1; IAdr = 34'h0_8000_0000; DAdr = 34'h0_A000_0000; DWrite = 1'b0; HREADY = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 8; c++) begin
      @(negedge clk);
      if (IDone || DDone) begin
        chk("alt_order", {DDone, IDone}, (cnt % 2 == 0) ? 2'b10 : 2'b01);
        cnt++;
      end
      drop_i = IDone;
      drop_d = DDone;
      @(posedge clk);
      #1;
      IReq = !drop_i;
      DReq = !drop_d;
    end
    chk("alt_count", cnt, 8);
    IReq = 1'b0; DReq = 1'b0;
    repeat (8) @(posedge clk);

    // Reset asserted while a write sits in the data phase.
    do_reset();
    @(posedge clk);
    #1;
    DReq = 1'b1; DAdr = 34'h0_8000_0040; DWrite = 1'b1; HREADY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_hwrite", HWRITE, 1'b1);
    @(negedge clk);
    chk("rstmid_hsel_data", HSELData, 11'h002);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_outputs", {HTRANS, HADDR, HWRITE, HSELData, IDone, DDone, BusErr}, 64'd0);
    DReq = 1'b0; HREADY = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_no_done", {IDone, DDone, BusErr}, 3'b000);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_vec('{ireq:1'b0, dreq:1'b1, adr:34'h0_8000_0040, wr:1'b1, wait_cyc:0, exp_done:3, exp_berr:1'b0, exp_hsel:11'h002});

    // Slave never ready.
    @(posedge clk);
    #1;
    IReq = 1'b1; IAdr = 34'h0_8000_0000; HREADY = 1'b0;
    first = -1;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if ((IDone || DDone) && first < 0) begin
        first = c;
        cnt = int'(BusErr);
      end
    end
`ifdef OPENHW_UNCORE_SCHED_TIMEOUT_EN
    chk("timeout_done_cycle", first, 11);
    chk("timeout_berr", cnt, 1);
`else
    chk("no_timeout_done", first, -1);
    @(posedge clk);
    #1 HREADY = 1'b1;
    @(negedge clk);
    chk("stuck_release_early", IDone, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("stuck_release_done", {IDone, BusErr}, 2'b10);
`endif
    @(posedge clk);
    #1;
    IReq = 1'b0; HREADY = 1'b1;
    repeat (4) @(posedge clk);

    // Random traffic against a transaction-level model (index 0 = I, 1 = D).
    do_reset();
    begin
      bit          pend[2];
      logic [33:0] padr[2];
      bit          pwr, have, unm, hr, prev_free, e_id, e_dd, e_be;
      bit [1:0]    prev_elig;
      logic [1:0]  e_tr;
      logic [10:0] e_hsel;
      logic [33:0] xadr;
      int          own, last_own, addr_c, done_c, lowrun;
      localparam int UNKNOWN = 1 << 30;
      pend[0] = 1'b0; pend[1] = 1'b0; padr[0] = '0; padr[1] = '0;
      pwr = 1'b0; have = 1'b0; unm = 1'b0; xadr = '0;
      prev_free = 1'b1; prev_elig = 2'b00;
      own = 0; last_own = 0; addr_c = 0; done_c = 0; lowrun = 0;
      for (int n = 0; n < 3000; n++) begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
          if (!pend[k] && $urandom_range(3) == 0) begin
            pend[k] = 1'b1;
            padr[k] = rand_adr();
            if (k == 1) pwr = 1'($urandom_range(1));
          end
        end
        hr = ($urandom_range(2) != 0) || (lowrun >= 3);
        lowrun = hr ? 0 : lowrun + 1;
        IReq = pend[0]; IAdr = padr[0];
        DReq = pend[1]; DAdr = padr[1]; DWrite = pwr;
        HREADY = hr;
        @(negedge clk);
        e_tr = 2'b00; e_hsel = '0; e_id = 1'b0; e_dd = 1'b0; e_be = 1'b0;
        if (have && n == done_c) begin
          e_id = (own == 0);
          e_dd = (own == 1);
          e_be = unm;
          have = 1'b0;
          pend[own] = 1'b0;
          last_own = own;
        end else if (have && n > addr_c) begin
          e_hsel = sel_of(xadr);
          if (!unm && hr && done_c == UNKNOWN) done_c = n + 1;
        end else if (!have && prev_free && prev_elig != 2'b00) begin
          own = (prev_elig == 2'b11) ? 1 - last_own : (prev_elig[1] ? 1 : 0);
          have = 1'b1;
          addr_c = n;
          xadr = padr[own];
          unm = !xadr[31];
          done_c = unm ? n + 3 : UNKNOWN;
          e_tr = 2'b10;
          chk("rnd_haddr", HADDR, xadr);
          chk("rnd_hwrite", HWRITE, (own == 1) && pwr);
        end
        chk("rnd_htrans", HTRANS, e_tr);
        chk("rnd_hsel", HSELData, e_hsel);
        chk("rnd_done", {IDone, DDone, BusErr}, {e_id, e_dd, e_be});
        prev_free = !have;
        prev_elig = {pend[1], pend[0]};
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
